// File: rtl/key_pkg.sv
// key_pkg: shared types and helpers for the 4x4 keypad scanner.
//   state_t     : scanner FSM states
//   COL_RST     : column strobe pattern after reset (column 0 driven low)
//   KEY_W       : width of a key code
//   key_code_of : row_idx*4 + col_idx
//   col_to_idx  : active-low one-cold column strobe -> column index
//   row_to_idx  : active-low row vector -> index of the lowest low row
package key_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, WAIT_REL} state_t;

    localparam logic [3:0] COL_RST = 4'b1110;
    localparam int         KEY_W   = 4;

    // row*4 + col is just the two indices concatenated.
    function automatic logic [KEY_W-1:0] key_code_of(input logic [1:0] row_idx,
                                                     input logic [1:0] col_idx);
        return {row_idx, col_idx};
    endfunction

    function automatic logic [1:0] col_to_idx(input logic [3:0] col_n);
        case (col_n)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Several rows low at once: the lowest-numbered row wins.
    function automatic logic [1:0] row_to_idx(input logic [3:0] row_n);
        if (!row_n[0])      return 2'd0;
        else if (!row_n[1]) return 2'd1;
        else if (!row_n[2]) return 2'd2;
        else                return 2'd3;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: free-running timebase, one-cycle tick every SCAN_MAX+1 clks.
//   clk       : system clock
//   sys_rst_p : synchronous active-high reset (counter back to 0)
//   tick      : high for the single cycle where the counter equals SCAN_MAX
module scan_tick_gen #(
    parameter int SCAN_MAX = 49_999
) (
    input  logic clk,
    input  logic sys_rst_p,
    output logic tick
);

    localparam int            CW       = (SCAN_MAX > 0) ? $clog2(SCAN_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_MAX);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (sys_rst_p)             cnt <= '0;
        else if (cnt == CNT_LAST)  cnt <= '0;
        else                       cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/key_scan_4x4.sv
// key_scan_4x4: scanning 4x4 matrix keypad reader with press/release debounce.
//   clk       : system clock
//   sys_rst_p : synchronous active-high reset
//   row_n     : keypad rows, active-low, asynchronous (2-flop synchronized)
//   col_n     : column strobes, exactly one bit low, rotates on scan ticks
//   key_code  : last accepted key, row_idx*4 + col_idx
//   key_valid : one-clk pulse whenever key_code is (re)reported
//   key_down  : high while an accepted key is held
// Optional build macro KEY_REPEAT_EN: while a key stays held, re-pulse
// key_valid after REPEAT_DELAY ticks and then every REPEAT_RATE ticks.
module key_scan_4x4
    import key_pkg::*;
#(
    parameter int SCAN_MAX     = 49_999,
    parameter int DEB_TICKS    = 10,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic             clk,
    input  logic             sys_rst_p,
    input  logic [3:0]       row_n,
    output logic [3:0]       col_n,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_down
);

    if (DEB_TICKS < 1 || DEB_TICKS > 15 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("key_scan_4x4: DEB_TICKS must be 1..15, repeat timings >= 1");
    end

    // deb_cnt starts at 0 on the tick that first sees a change and must reach
    // DEB_TICKS-1, so DEB_TICKS stable ticks are seen in total.  DEB_TICKS=1
    // still needs one confirming tick.
    localparam logic [3:0] DEB_LAST = 4'((DEB_TICKS > 1) ? DEB_TICKS - 1 : 1);

    logic       tick;
    logic [3:0] row_m, row_s;
    logic [3:0] row_lat;
    logic [3:0] deb_cnt;
    logic [3:0] deb_nxt;
    logic       deb_last;
    logic [3:0] col_rot;
    state_t     state;

    scan_tick_gen #(.SCAN_MAX(SCAN_MAX)) u_tick (
        .clk       (clk),
        .sys_rst_p (sys_rst_p),
        .tick      (tick)
    );

    always_ff @(posedge clk) begin
        if (sys_rst_p) begin
            row_m <= 4'hF;
            row_s <= 4'hF;
        end else begin
            row_m <= row_n;
            row_s <= row_m;
        end
    end

    assign deb_nxt  = deb_cnt + 4'd1;
    assign deb_last = (deb_nxt >= DEB_LAST);
    assign col_rot  = {col_n[2:0], col_n[3]};

`ifdef KEY_REPEAT_EN
    localparam int            RW        = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_WRAP  = RW'(REPEAT_DELAY + REPEAT_RATE);

    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_nxt;

    assign rep_nxt = rep_cnt + 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (sys_rst_p) begin
            state     <= SCAN;
            col_n     <= COL_RST;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            deb_cnt   <= '0;
            row_lat   <= 4'hF;
`ifdef KEY_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (row_s == 4'hF) begin
                            col_n <= col_rot;
                        end else begin
                            row_lat <= row_s;
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (row_s != row_lat) begin
                            col_n <= col_rot;
                            state <= SCAN;
                        end else if (deb_last) begin
                            key_code  <= key_code_of(row_to_idx(row_lat), col_to_idx(col_n));
                            key_valid <= 1'b1;
                            key_down  <= 1'b1;
                            deb_cnt   <= '0;
                            state     <= WAIT_REL;
`ifdef KEY_REPEAT_EN
                            rep_cnt   <= '0;
`endif
                        end else begin
                            deb_cnt <= deb_nxt;
                        end
                    end
                    WAIT_REL: begin
                        // Column stays put; a key in another column is
                        // invisible until this one is released.
                        if (row_s == 4'hF) begin
`ifdef KEY_REPEAT_EN
                            rep_cnt <= '0;
`endif
                            if (deb_last) begin
                                key_down <= 1'b0;
                                deb_cnt  <= '0;
                                col_n    <= col_rot;
                                state    <= SCAN;
                            end else begin
                                deb_cnt <= deb_nxt;
                            end
                        end else begin
                            deb_cnt <= '0;
`ifdef KEY_REPEAT_EN
                            if (row_s == row_lat) begin
                                // First repeat at REP_FIRST, then fold back
                                // so every REPEAT_RATE ticks re-hits the wrap.
                                if (rep_nxt == REP_FIRST) begin
                                    key_valid <= 1'b1;
                                    rep_cnt   <= rep_nxt;
                                end else if (rep_nxt == REP_WRAP) begin
                                    key_valid <= 1'b1;
                                    rep_cnt   <= REP_FIRST;
                                end else begin
                                    rep_cnt <= rep_nxt;
                                end
                            end
`endif
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_scan_4x4.sv
module tb_key_scan_4x4;

    logic        clk = 1'b0;
    logic        sys_rst_p;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] keys;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int vcount    = 0;
    int cyc       = 0;
    int stb_cyc [8];
    logic prev_v  = 1'b0;
    logic consec  = 1'b0;

    always #5 clk = ~clk;

    key_scan_4x4 #(
        .SCAN_MAX(9), .DEB_TICKS(3), .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) dut (
        .clk       (clk),
        .sys_rst_p (sys_rst_p),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    // Keypad matrix: key r*4+c pulls row r low while column c is strobed.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    // Strobe monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        cyc++;
        if (key_valid === 1'b1) begin
            if (vcount < 8) stb_cyc[vcount] = cyc;
            vcount++;
            if (prev_v) consec = 1'b1;
        end
        prev_v = (key_valid === 1'b1);
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait for col_n to switch into val; lands 0.5 clk after that tick edge.
    task automatic wait_col_edge(input logic [3:0] val, input string tag);
        logic [3:0] prev;
        int n;
        prev = col_n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (col_n == val && prev != val) break;
            prev = col_n;
        end while (n < 200);
        total_cnt++;
        if (n >= 200) $display("FAIL %s: col_n never reached %b (now %b)", tag, val, col_n);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        keys = '0;
        sys_rst_p = 1'b1;
        wait_clks(3);
        total_cnt++; if (col_n !== 4'b1110) $display("FAIL rst_col: got %b want 1110", col_n); else pass_cnt++;
        total_cnt++; if (key_code !== 4'd0) $display("FAIL rst_code: got %0d want 0", key_code); else pass_cnt++;
        total_cnt++; if (key_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", key_valid); else pass_cnt++;
        total_cnt++; if (key_down !== 1'b0) $display("FAIL rst_down: got %b want 0", key_down); else pass_cnt++;
        sys_rst_p = 1'b0;
    endtask

    // Idle rows: one rotation every 10 clks, first one 10 clks after reset.
    task automatic test_idle_scan;
        logic [3:0] exp_col, prev;
        int n;
        vcount = 0;
        exp_col = 4'b1110;
        for (int k = 0; k < 8; k++) begin
            exp_col = {exp_col[2:0], exp_col[3]};
            prev = col_n;
            n = 0;
            do begin @(negedge clk); n++; end while (col_n == prev && n < 20);
            total_cnt++;
            if (n !== 10 || col_n !== exp_col)
                $display("FAIL idle_rot%0d: got col %b after %0d clk, want %b after 10", k, col_n, n, exp_col);
            else pass_cnt++;
        end
        total_cnt++; if (vcount !== 0) $display("FAIL idle_novalid: got %0d strobes want 0", vcount); else pass_cnt++;
    endtask

    // Key 9 (row 2, col 1). E0 = tick selecting col 1; detect E1, accept E3.
    task automatic test_clean_press;
        vcount = 0;
        wait_col_edge(4'b1101, "press_sync");
        keys[9] = 1'b1;
        wait_clks(40);                                   // E4
        total_cnt++; if (vcount !== 1) $display("FAIL press_count: got %0d want 1", vcount); else pass_cnt++;
        total_cnt++; if (key_code !== 4'd9) $display("FAIL press_code: got %0d want 9", key_code); else pass_cnt++;
        total_cnt++; if (key_down !== 1'b1) $display("FAIL press_down: got %b want 1", key_down); else pass_cnt++;
        wait_clks(30);                                   // E7, still held
        total_cnt++; if (col_n !== 4'b1101) $display("FAIL press_hold_col: got %b want 1101", col_n); else pass_cnt++;
        total_cnt++; if (vcount !== 1) $display("FAIL press_once: got %0d want 1", vcount); else pass_cnt++;
        keys[9] = 1'b0;
        wait_clks(10);                                   // E8: first high tick, deb_cnt=1
        total_cnt++; if (col_n !== 4'b1101 || key_down !== 1'b1)
            $display("FAIL rel_pending: got col %b down %b want 1101/1", col_n, key_down); else pass_cnt++;
        wait_clks(10);                                   // E9: deb_cnt reaches 2
        total_cnt++; if (col_n !== 4'b1011 || key_down !== 1'b0)
            $display("FAIL rel_done: got col %b down %b want 1011/0", col_n, key_down); else pass_cnt++;
    endtask

    // Key 0: seen on E1, gone by E2 (abort), back and stable until col 0 returns.
    task automatic test_bounce;
        vcount = 0;
        wait_col_edge(4'b1110, "bounce_sync");
        keys[0] = 1'b1;
        wait_clks(10);                                   // E1: DEBOUNCE
        keys[0] = 1'b0;
        wait_clks(10);                                   // E2: mismatch -> rotate
        total_cnt++; if (col_n !== 4'b1101 || vcount !== 0)
            $display("FAIL bounce_abort: got col %b strobes %0d want 1101/0", col_n, vcount); else pass_cnt++;
        keys[0] = 1'b1;
        wait_clks(70);                                   // col0 at E5, detect E6, accept E8
        total_cnt++; if (vcount !== 1) $display("FAIL bounce_count: got %0d want 1", vcount); else pass_cnt++;
        total_cnt++; if (key_code !== 4'd0 || key_down !== 1'b1)
            $display("FAIL bounce_code: got %0d down %b want 0/1", key_code, key_down); else pass_cnt++;
        keys[0] = 1'b0;
        wait_clks(30);
        total_cnt++; if (key_down !== 1'b0) $display("FAIL bounce_rel: got %b want 0", key_down); else pass_cnt++;
    endtask

    // Keys 7 and 15 share column 3; row 1 is lower than row 3.
    task automatic test_multi_row;
        vcount = 0;
        wait_col_edge(4'b0111, "multi_sync");
        keys[7] = 1'b1; keys[15] = 1'b1;
        wait_clks(40);
        total_cnt++; if (key_code !== 4'd7) $display("FAIL multi_code: got %0d want 7", key_code); else pass_cnt++;
        total_cnt++; if (vcount !== 1) $display("FAIL multi_count: got %0d want 1", vcount); else pass_cnt++;
        keys = '0;
        wait_clks(30);
    endtask

    task automatic test_reset_mid;
        // Mid-DEBOUNCE on key 5 (key_code still 7 from before).
        vcount = 0;
        wait_col_edge(4'b1101, "rstdeb_sync");
        keys[5] = 1'b1;
        wait_clks(15);                                   // past detect, before accept
        sys_rst_p = 1'b1;
        wait_clks(1);
        total_cnt++; if (col_n !== 4'b1110 || key_down !== 1'b0 || key_code !== 4'd0 || key_valid !== 1'b0)
            $display("FAIL rst_deb: got col %b down %b code %0d valid %b want 1110/0/0/0",
                     col_n, key_down, key_code, key_valid); else pass_cnt++;
        keys = '0;
        sys_rst_p = 1'b0;
        wait_clks(50);
        total_cnt++; if (vcount !== 0) $display("FAIL rst_deb_novalid: got %0d want 0", vcount); else pass_cnt++;
        // Mid-WAIT_REL on key 9.
        wait_col_edge(4'b1101, "rstwr_sync");
        keys[9] = 1'b1;
        wait_clks(40);
        total_cnt++; if (key_down !== 1'b1 || key_code !== 4'd9)
            $display("FAIL rst_wr_pre: got down %b code %0d want 1/9", key_down, key_code); else pass_cnt++;
        vcount = 0;
        sys_rst_p = 1'b1;
        wait_clks(1);
        total_cnt++; if (col_n !== 4'b1110 || key_down !== 1'b0 || key_code !== 4'd0 || key_valid !== 1'b0)
            $display("FAIL rst_wr: got col %b down %b code %0d valid %b want 1110/0/0/0",
                     col_n, key_down, key_code, key_valid); else pass_cnt++;
        keys = '0;
        sys_rst_p = 1'b0;
        wait_clks(50);
        total_cnt++; if (vcount !== 0) $display("FAIL rst_wr_novalid: got %0d want 0", vcount); else pass_cnt++;
    endtask

    // Key 5 accepted at E3, held until E15 (12 ticks after acceptance).
    task automatic test_repeat;
        int exp_n;
        int exp_off [5];
        exp_off = '{0, 50, 70, 90, 110};
`ifdef KEY_REPEAT_EN
        exp_n = 5;
`else
        exp_n = 1;
`endif
        vcount = 0;
        wait_col_edge(4'b1101, "rep_sync");
        keys[5] = 1'b1;
        wait_clks(150);                                  // E15
        keys = '0;
        wait_clks(30);
        total_cnt++; if (vcount !== exp_n) $display("FAIL rep_count: got %0d want %0d", vcount, exp_n); else pass_cnt++;
        for (int i = 1; i < exp_n && i < vcount; i++) begin
            total_cnt++;
            if (stb_cyc[i] - stb_cyc[0] !== exp_off[i])
                $display("FAIL rep_off%0d: got %0d clk want %0d", i, stb_cyc[i] - stb_cyc[0], exp_off[i]);
            else pass_cnt++;
        end
        total_cnt++; if (key_code !== 4'd5 || key_down !== 1'b0)
            $display("FAIL rep_end: got code %0d down %b want 5/0", key_code, key_down); else pass_cnt++;
        total_cnt++; if (consec !== 1'b0) $display("FAIL valid_consec: got %b want 0", consec); else pass_cnt++;
    endtask

    initial begin
        keys = '0;
        sys_rst_p = 1'b1;
        @(negedge clk);
        test_reset();
        test_idle_scan();
        test_clean_press();
        test_bounce();
        test_multi_row();
        test_reset_mid();
        test_repeat();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
